// File: rtl/cic_vco_pkg.sv
// Shared types and sizing helpers for the multi-channel VCO CIC decimator.
package cic_vco_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } state_e;

   function automatic int ow_calc(int iw, int order, int rmax_log2);
      return iw + 1 + order * rmax_log2;
   endfunction

   function automatic int dec_w_calc(int rmax_log2);
      return $clog2(rmax_log2 + 1);
   endfunction

   localparam int RMAX_LOG2_DEF = 4;
   localparam int DEC_W_DEF     = dec_w_calc(RMAX_LOG2_DEF);

endpackage

// File: rtl/cic_vco_channel.sv
// One channel: phase differencing, integrator chain, decimated comb chain
// and the output register. Sequencing comes from the top.
module cic_vco_channel
   import cic_vco_pkg::*;
#(
   parameter int IW    = 6,
   parameter int ORDER = 3,
   parameter int OW    = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          run,
   input  logic          tick,
   input  logic [IW-1:0] in_p,
   input  logic [IW-1:0] in_m,
   output logic [OW-1:0] out
);

   logic [IW-1:0] prev_p_q, prev_p_d;
   logic [IW-1:0] prev_m_q, prev_m_d;
   logic [IW-1:0] dp, dm;
   logic [IW:0]   d;
   logic [OW-1:0] integ_q [ORDER];
   logic [OW-1:0] integ_d [ORDER];
   logic [OW-1:0] dly_q [ORDER];
   logic [OW-1:0] dly_d [ORDER];
   logic [OW-1:0] x;
   logic [OW-1:0] res_q, res_d;
   logic [OW-1:0] out_q, out_d;
   logic          ld_q, ld_d;

   always_comb begin
      dp       = in_p - prev_p_q;
      dm       = in_m - prev_m_q;
      d        = {1'b0, dp} - {1'b0, dm};
      x        = integ_q[ORDER-1];
      prev_p_d = prev_p_q;
      prev_m_d = prev_m_q;
      integ_d  = integ_q;
      dly_d    = dly_q;
      res_d    = res_q;
      ld_d     = 1'b0;
      out_d    = out_q;
      if (clr) begin
         prev_p_d = in_p;
         prev_m_d = in_m;
         for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = '0;
            dly_d[k]   = '0;
         end
         res_d = '0;
      end else if (run) begin
         prev_p_d   = in_p;
         prev_m_d   = in_m;
         integ_d[0] = integ_q[0] + {{(OW-IW-1){d[IW]}}, d};
         for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
         end
         // Combs run at the decimated rate; result lands in OUT next edge.
         if (tick) begin
            for (int k = 0; k < ORDER; k++) begin
               dly_d[k] = x;
               x        = x - dly_q[k];
            end
            res_d = x;
            ld_d  = 1'b1;
         end
         if (ld_q) begin
            out_d = res_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_p_q <= '0;
         prev_m_q <= '0;
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
         res_q <= '0;
         ld_q  <= 1'b0;
         out_q <= '0;
      end else begin
         prev_p_q <= prev_p_d;
         prev_m_q <= prev_m_d;
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= integ_d[k];
            dly_q[k]   <= dly_d[k];
         end
         res_q <= res_d;
         ld_q  <= ld_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/cic_vco_decimator_mc.sv
// Multi-channel differential VCO CIC decimator: run FSM, ratio latch,
// tick generation and valid strobe; the channels carry the arithmetic.
module cic_vco_decimator_mc
   import cic_vco_pkg::*;
#(
   parameter  int NCH       = 4,
   parameter  int IW        = 6,
   parameter  int ORDER     = 3,
   parameter  int RMAX_LOG2 = 4,
   localparam int OW        = ow_calc(IW, ORDER, RMAX_LOG2),
   localparam int DW        = dec_w_calc(RMAX_LOG2)
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              ENABLE,
   input  logic [DW-1:0]     DEC_LOG2,
   input  logic [NCH*IW-1:0] IN_p,
   input  logic [NCH*IW-1:0] IN_m,
   output logic [NCH*OW-1:0] OUT,
   output logic              OUT_VALID,
   output logic              BUSY
);

   localparam int CW = RMAX_LOG2;
   localparam int FW = $clog2(ORDER + 1);

   state_e        state_q, state_d;
   logic [DW-1:0] r_log2_q, r_log2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          pend_q, pend_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] dec_clamp;
   logic [CW-1:0] rmask;
   logic          busy;
   logic          run;
   logic          clr;
   logic          tick;

   assign dec_clamp = (DEC_LOG2 > DW'(RMAX_LOG2)) ?
                      DW'(RMAX_LOG2) : DEC_LOG2;
   assign rmask = CW'((32'd1 << r_log2_q) - 32'd1);
   assign busy  = (state_q != IDLE);
   assign run   = busy && ENABLE;
   assign clr   = (state_q == IDLE) && ENABLE;
   assign tick  = run && (cnt_q == rmask);

   always_comb begin
      state_d  = state_q;
      r_log2_d = r_log2_q;
      cnt_d    = cnt_q;
      fcnt_d   = fcnt_q;
      pend_d   = 1'b0;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ENABLE) begin
               state_d  = FLUSH;
               r_log2_d = dec_clamp;
               cnt_d    = '0;
               fcnt_d   = '0;
            end
         end
         FLUSH: begin
            if (!ENABLE) begin
               state_d = IDLE;
            end else begin
               cnt_d = tick ? '0 : cnt_q + CW'(1);
               // Results stay hidden until the comb delays hold real data.
               if (tick) begin
                  if (fcnt_q == FW'(ORDER)) begin
                     state_d = RUN;
                  end else begin
                     fcnt_d = fcnt_q + FW'(1);
                  end
               end
            end
         end
         RUN: begin
            if (!ENABLE) begin
               state_d = IDLE;
            end else begin
               cnt_d   = tick ? '0 : cnt_q + CW'(1);
               pend_d  = tick;
               valid_d = pend_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RES) begin
         state_q  <= IDLE;
         r_log2_q <= '0;
         cnt_q    <= '0;
         fcnt_q   <= '0;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_log2_q <= r_log2_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      cic_vco_channel #(
         .IW    (IW),
         .ORDER (ORDER),
         .OW    (OW)
      ) u_ch (
         .clk   (CLK),
         .rst_n (RES),
         .clr   (clr),
         .run   (run),
         .tick  (tick),
         .in_p  (IN_p[c*IW +: IW]),
         .in_m  (IN_m[c*IW +: IW]),
         .out   (OUT[c*OW +: OW])
      );
   end

   assign OUT_VALID = valid_q;
   assign BUSY      = busy;

endmodule

// File: tb/tb_cic_vco_decimator_mc.sv
// Directed + randomized bench for cic_vco_decimator_mc against an
// arithmetic CIC reference (prefix sums, binomial N-th difference).
module tb_cic_vco_decimator_mc;
   import cic_vco_pkg::*;

   localparam int NCH       = 4;
   localparam int IW        = 6;
   localparam int ORDER     = 3;
   localparam int RMAX_LOG2 = RMAX_LOG2_DEF;
   localparam int OW        = ow_calc(IW, ORDER, RMAX_LOG2);
   localparam int DW        = DEC_W_DEF;
   localparam int PM        = (1 << IW) - 1;

   logic              clk = 1'b0;
   logic              res_n;
   logic              enable;
   logic [DW-1:0]     dec_log2;
   logic [NCH*IW-1:0] in_p_v;
   logic [NCH*IW-1:0] in_m_v;
   logic [NCH*OW-1:0] out_v;
   logic              out_valid;
   logic              busy;

   always #5 clk = ~clk;

   cic_vco_decimator_mc dut (
      .CLK       (clk),
      .RES       (res_n),
      .ENABLE    (enable),
      .DEC_LOG2  (dec_log2),
      .IN_p      (in_p_v),
      .IN_m      (in_m_v),
      .OUT       (out_v),
      .OUT_VALID (out_valid),
      .BUSY      (busy)
   );

   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   int     ph_p[NCH];
   int     ph_m[NCH];
   int     dl_p[NCH];
   int     dl_m[NCH];
   bit     rnd_dl = 1'b0;
   int     n_edge;
   int     first_v;
   int     nval;
   longint last[NCH];

   bit     m_act, m_pend, m_pend_run, m_valid;
   int     m_e, m_k, m_r;
   int     m_pp[NCH];
   int     m_pm[NCH];
   longint m_i[NCH][ORDER];
   longint m_x[NCH][$];
   longint m_out[NCH];
   longint m_nxt[NCH];

   function automatic longint binom(int n, int k);
      longint r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   function automatic longint wrap_ow(longint v);
      longint m;
      m = v & ((longint'(1) << OW) - 1);
      if (m >= (longint'(1) << (OW - 1))) m = m - (longint'(1) << OW);
      return m;
   endfunction

   task automatic check(string tag, logic signed [63:0] obs,
                        logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int     rl;
      int     sz;
      longint d;
      longint y;
      longint sg;
      bit     tk;
      if (!res_n) begin
         m_act   = 1'b0;
         m_pend  = 1'b0;
         m_valid = 1'b0;
         for (int c = 0; c < NCH; c++) m_out[c] = 0;
      end else if (!m_act) begin
         m_valid = 1'b0;
         if (enable) begin
            rl     = (int'(dec_log2) > RMAX_LOG2) ? RMAX_LOG2 : int'(dec_log2);
            m_r    = 1 << rl;
            m_act  = 1'b1;
            m_e    = 0;
            m_k    = 0;
            m_pend = 1'b0;
            for (int c = 0; c < NCH; c++) begin
               m_pp[c] = ph_p[c];
               m_pm[c] = ph_m[c];
               for (int k = 0; k < ORDER; k++) m_i[c][k] = 0;
               m_x[c].delete();
            end
         end
      end else if (!enable) begin
         m_act   = 1'b0;
         m_pend  = 1'b0;
         m_valid = 1'b0;
      end else begin
         m_valid = m_pend && m_pend_run;
         if (m_pend) begin
            for (int c = 0; c < NCH; c++) m_out[c] = m_nxt[c];
         end
         m_pend = 1'b0;
         m_e++;
         tk = ((m_e % m_r) == 0);
         for (int c = 0; c < NCH; c++) begin
            d = longint'((ph_p[c] - m_pp[c]) & PM)
              - longint'((ph_m[c] - m_pm[c]) & PM);
            m_pp[c] = ph_p[c];
            m_pm[c] = ph_m[c];
            if (tk) begin
               m_x[c].push_back(m_i[c][ORDER-1]);
               if (m_x[c].size() > ORDER + 1) void'(m_x[c].pop_front());
               sz = m_x[c].size();
               y  = 0;
               for (int j = 0; j <= ORDER; j++) begin
                  sg = (j % 2 == 1) ? -1 : 1;
                  if (sz - 1 - j >= 0) y += sg * binom(ORDER, j) * m_x[c][sz-1-j];
               end
               m_nxt[c] = wrap_ow(y);
            end
            for (int k = ORDER - 1; k > 0; k--) m_i[c][k] += m_i[c][k-1];
            m_i[c][0] += d;
         end
         if (tk) begin
            m_k++;
            m_pend     = 1'b1;
            m_pend_run = (m_k >= ORDER + 2);
         end
      end
   endtask

   task automatic step();
      logic signed [63:0] o;
      for (int c = 0; c < NCH; c++) begin
         in_p_v[c*IW +: IW] = IW'(ph_p[c]);
         in_m_v[c*IW +: IW] = IW'(ph_m[c]);
      end
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_act);
      for (int c = 0; c < NCH; c++) begin
         o = $signed(out_v[c*OW +: OW]);
         check($sformatf("out_ch%0d", c), o, m_out[c]);
      end
      if (out_valid === 1'b1) begin
         nval++;
         if (first_v < 0) first_v = cyc - n_edge;
         for (int c = 0; c < NCH; c++) last[c] = $signed(out_v[c*OW +: OW]);
      end
      for (int c = 0; c < NCH; c++) begin
         if (rnd_dl) begin
            dl_p[c] = $urandom_range(0, PM);
            dl_m[c] = $urandom_range(0, PM);
         end
         ph_p[c] = (ph_p[c] + dl_p[c]) & PM;
         ph_m[c] = (ph_m[c] + dl_m[c]) & PM;
      end
   endtask

   task automatic start(int dec);
      dec_log2 = DW'(dec);
      enable   = 1'b1;
      n_edge   = cyc + 1;
      first_v  = -1;
      nval     = 0;
      step();
   endtask

   task automatic stop();
      enable = 1'b0;
      step();
   endtask

   task automatic set_dl(int c, int p, int m);
      dl_p[c] = p;
      dl_m[c] = m;
   endtask

   initial begin
      res_n    = 1'b0;
      enable   = 1'b0;
      dec_log2 = '0;
      n_edge   = 0;
      first_v  = -1;
      nval     = 0;
      for (int c = 0; c < NCH; c++) begin
         ph_p[c] = 0;
         ph_m[c] = 0;
         set_dl(c, 0, 0);
         last[c] = 0;
      end
      step();
      step();
      res_n = 1'b1;
      step();

      // R = 4 basic run
      set_dl(0, 5, 3);
      set_dl(1, 3, 5);
      set_dl(2, 7, 7);
      set_dl(3, 1, 1);
      start(2);
      repeat (50) step();
      check("lat_r4", first_v, 21);
      check("nval_r4", nval, 8);
      check("r4_ch0", last[0], 128);
      check("r4_ch1", last[1], -128);
      check("r4_ch2", last[2], 0);
      check("r4_ch3", last[3], 0);

      // drop ENABLE mid-run, ratio change ignored while busy
      enable   = 1'b0;
      dec_log2 = DW'(1);
      step();
      check("hold_ch0", $signed(out_v[0 +: OW]), 128);
      check("drop_valid", out_valid, 1'b0);
      check("drop_busy", busy, 1'b0);
      step();
      start(1);
      repeat (40) step();
      check("lat_r2", first_v, 11);
      check("r2_ch0", last[0], 16);
      check("r2_ch1", last[1], -16);
      stop();

      // random phase offsets, wrapping continuously
      for (int c = 0; c < NCH; c++) begin
         ph_p[c] = $urandom_range(0, PM);
         ph_m[c] = $urandom_range(0, PM);
      end
      start(2);
      repeat (50) step();
      check("wrap_lat", first_v, 21);
      check("wrap_ch0", last[0], 128);
      check("wrap_ch1", last[1], -128);
      check("wrap_ch2", last[2], 0);
      stop();

      // full-scale d at maximum ratio, then clamped ratio
      set_dl(0, 63, 0);
      set_dl(1, $urandom_range(0, PM), $urandom_range(0, PM));
      start(4);
      repeat (100) step();
      check("lat_r16", first_v, 81);
      check("r16_ch0", last[0], 258048);
      stop();
      start(7);
      repeat (100) step();
      check("lat_clamp", first_v, 81);
      check("clamp_ch0", last[0], 258048);
      stop();

      // R = 1: continuous strobe
      set_dl(0, 5, 3);
      set_dl(1, 3, 5);
      start(0);
      repeat (30) step();
      check("lat_r1", first_v, 6);
      check("nval_r1", nval, 25);
      check("r1_ch0", last[0], 2);
      stop();

      // reset pulse mid-run with ENABLE held
      start(2);
      repeat (30) step();
      res_n = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("rst_ch%0d", c), $signed(out_v[c*OW +: OW]), 0);
      end
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      res_n   = 1'b1;
      n_edge  = cyc + 1;
      first_v = -1;
      nval    = 0;
      step();
      repeat (30) step();
      check("rst_lat", first_v, 21);
      check("rst_ch0", last[0], 128);

      // randomized deltas, ratios and ENABLE drops
      rnd_dl = 1'b1;
      repeat (4) begin
         stop();
         start($urandom_range(0, 7));
         repeat (150) begin
            dec_log2 = DW'($urandom_range(0, 7));
            enable   = ($urandom_range(0, 59) != 0);
            step();
         end
      end
      stop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
